unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares the single-port, byte-addressed unified memory between the instruction-fetch (IF) requester and the load/store (MEM-stage) requester.
- Grants one requester per cycle and drives the memory's MemRead/MemWrite/funct3/addr/data_in pins.
- Registers read data back to the winner and provides stall information to the pipeline.
- Sits between the core's IF/MEM stages and the memory; the hazard unit uses if_gnt to stall fetch.

Parameters:
- ADDR_W, 8, memory byte-address width.
- MAX_DATA_RUN, 4, maximum consecutive contested data grants before fetch is forced through (range 1..15).
- STAT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  clock; all registers on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  combinational; fetch accepted this cycle.
- if_rvalid  out  1  registered; one-cycle pulse, instruction in if_rdata.
- if_rdata  out  32  registered instruction word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  RISC-V load/store funct3.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  combinational; data access accepted this cycle.
- d_ack  out  1  registered; one-cycle pulse after any granted data access.
- d_rdata  out  32  registered load result.
- mem_MemRead  out  1  to memory MemRead.
- mem_MemWrite  out  1  to memory MemWrite.
- mem_funct3  out  3  to memory funct3.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  32  to memory data_in.
- mem_rdata  in  32  from memory data_out; combinational read.

Behaviour:

Handshake
- A transfer occurs in a cycle where req && gnt.
- The requester holds req and its payload until it sees gnt. It may change the payload on the following cycle.

Arbitration (combinational)
- d_gnt = d_req && !rst && (!if_req || run_cnt < MAX_DATA_RUN).
- if_gnt = if_req && !rst && !d_gnt.
- At most one grant per cycle.

Run counter (run_cnt, 4-bit register)
- Contested data grant (d_gnt && if_req): run_cnt increments, saturating at MAX_DATA_RUN.
- if_gnt, or if_req low: run_cnt clears to 0.

Memory drive
- Data load: MemRead=1, MemWrite=0, funct3=d_funct3, addr=d_addr.
- Data store: MemRead=0, MemWrite=1, funct3=d_funct3, addr=d_addr, wdata=d_wdata.
- Fetch: MemRead=0, MemWrite=0, funct3=3'b010, addr=if_addr (memory returns the aligned-order word when MemRead=0).
- No grant: all mem_* outputs 0.
- mem_MemWrite is forced to 0 whenever rst=1.

Response path (latency 1)
- Cycle N with if_gnt: if_rdata<=mem_rdata at the end of N; if_rvalid=1 in N+1.
- Cycle N with d_gnt: d_ack=1 in N+1. On a load, d_rdata<=mem_rdata. On a store, d_rdata holds its value and the memory writes at the end of N.
- Back-to-back grants to the same port produce back-to-back valid/ack pulses.

Address and funct3 handling
- Addresses pass unchanged; wrap-around at 2^ADDR_W belongs to the memory.
- Unsupported funct3 values are forwarded unchanged.

Reset
- rst=1 forces run_cnt, if_rvalid, if_rdata, d_ack and d_rdata to 0 immediately; mem_* outputs are 0; no write occurs.
- Any pending valid/ack pulse is dropped.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs stat_if_stall and stat_d_gnt, each STAT_W wide.
  - stat_if_stall increments each cycle with if_req && !if_gnt.
  - stat_d_gnt increments on each d_gnt.
  - Both saturate at all-ones and clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared defines header holds the funct3 encodings (LW/LH/LB/LBU/LHU/SW/SH/SB) and the IR field ranges already used by the memory.
- One sub-module, mem_arb_grant: pure grant logic plus the run counter. The top level keeps the mux and response registers.

Test Plan:
- Reset, then if_req=1 with if_addr=4, d_req=0 → if_gnt=1 that cycle; next cycle if_rvalid=1 and if_rdata=32'h04002083 (lw x1,64(x0)).
- d_req=1 (load, funct3=010, addr=64) together with if_req=1 → d_gnt=1, if_gnt=0; next cycle d_ack=1, d_rdata=17. Fetch is granted on the following cycle.
- Both requests held high continuously with MAX_DATA_RUN=4 → grant pattern is D,D,D,D,F repeating; run_cnt returns to 0 after each F.
- Store funct3=000, addr=80, wdata=32'hA5 → mem_MemWrite=1 for exactly one cycle; a later LBU of addr 80 returns 32'h000000A5, and LB of addr 80 returns 32'hFFFFFFA5.
- Assert rst in the same cycle as a granted store to addr 76 → no write occurs (LW 76 afterward returns its prior value), and d_ack stays 0.
- With MEM_ARB_STATS_EN, 10 contested cycles → stat_if_stall=8 and stat_d_gnt=8.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// ============================================================================
// Module      : unified_mem_arbiter_pkg
// Description : Shared funct3 encodings, IR field ranges and grant-select type
//               for the unified memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package unified_mem_arbiter_pkg;

    // RISC-V load/store funct3 encodings, as decoded by the memory
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    // Instruction-register field ranges
    localparam int c_ir_opcode_lsb = 0;
    localparam int c_ir_opcode_msb = 6;
    localparam int c_ir_rd_lsb     = 7;
    localparam int c_ir_rd_msb     = 11;
    localparam int c_ir_funct3_lsb = 12;
    localparam int c_ir_funct3_msb = 14;
    localparam int c_ir_rs1_lsb    = 15;
    localparam int c_ir_rs1_msb    = 19;
    localparam int c_ir_rs2_lsb    = 20;
    localparam int c_ir_rs2_msb    = 24;
    localparam int c_ir_funct7_lsb = 25;
    localparam int c_ir_funct7_msb = 31;

    typedef enum logic [1:0] {
        c_sel_none  = 2'd0,
        c_sel_fetch = 2'd1,
        c_sel_data  = 2'd2
    } mem_sel_e;

    function automatic mem_sel_e grant_sel(input logic if_gnt, input logic d_gnt);
        if (d_gnt)
            return c_sel_data;
        else if (if_gnt)
            return c_sel_fetch;
        else
            return c_sel_none;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// ============================================================================
// Module      : mem_arb_grant
// Description : Data-priority grant logic with a bounded run of contested data
//               grants before fetch is forced through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_grant #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam logic [3:0] c_max_run = 4'(MAX_DATA_RUN);

    logic [3:0] r_run_cnt;

    assign d_gnt  = d_req && !rst && (!if_req || (r_run_cnt < c_max_run));
    assign if_gnt = if_req && !rst && !d_gnt;

    // Counts only data wins that made fetch wait; any other cycle restarts the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= 4'd0;
        end else if (d_gnt && if_req) begin
            if (r_run_cnt < c_max_run)
                r_run_cnt <= r_run_cnt + 4'd1;
        end else begin
            r_run_cnt <= 4'd0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares the unified memory between fetch and load/store ports.
//               Optional statistics counters under `MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int MAX_DATA_RUN = 4,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_if_stall,
    output logic [STAT_W-1:0] stat_d_gnt
`endif
);

    logic     w_if_gnt;
    logic     w_d_gnt;
    mem_sel_e w_sel;

    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_d_ack;
    logic [31:0] r_d_rdata;

    mem_arb_grant #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_grant (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (w_if_gnt),
        .d_gnt  (w_d_gnt)
    );

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign w_sel     = grant_sel(w_if_gnt, w_d_gnt);
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;

    // Grants already include !rst, so no write can reach the memory during reset
    always_comb begin
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        mem_funct3   = 3'b000;
        mem_addr     = '0;
        mem_wdata    = 32'd0;
        case (w_sel)
            c_sel_data: begin
                mem_MemRead  = !d_we;
                mem_MemWrite = d_we;
                mem_funct3   = d_funct3;
                mem_addr     = d_addr;
                if (d_we)
                    mem_wdata = d_wdata;
            end
            c_sel_fetch: begin
                mem_funct3 = c_f3_lw;
                mem_addr   = if_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_ack     <= 1'b0;
            r_d_rdata   <= 32'd0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_d_ack     <= w_d_gnt;
            if (w_if_gnt)
                r_if_rdata <= mem_rdata;
            if (w_d_gnt && !d_we)
                r_d_rdata <= mem_rdata;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_if_stall;
    logic [STAT_W-1:0] r_stat_d_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_if_stall <= '0;
            r_stat_d_gnt    <= '0;
        end else begin
            if (if_req && !w_if_gnt && !(&r_stat_if_stall))
                r_stat_if_stall <= r_stat_if_stall + STAT_W'(1);
            if (w_d_gnt && !(&r_stat_d_gnt))
                r_stat_d_gnt <= r_stat_d_gnt + STAT_W'(1);
        end
    end

    assign stat_if_stall = r_stat_if_stall;
    assign stat_d_gnt    = r_stat_d_gnt;
`else
    logic w_unused_stat_w;
    assign w_unused_stat_w = (STAT_W > 0);
`endif

endmodule

`default_nettype wire
